vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_scanout_if.sv | 31 +++
 rtl/vga_sync_counter.sv | 62 ++++++
 rtl/vga_scanout.sv | 96 +++++++++
 tb/tb_vga_scanout.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing defaults, counter/colour widths and the packed pixel layout.
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Counters are sized for totals up to 1023 so both axes share one width.
  localparam int CNT_W    = 10;
  localparam int DRAW_X_W = 10;
  localparam int DRAW_Y_W = 9;

  localparam int CHAN_W  = 3;
  localparam int COLOR_W = 3 * CHAN_W;
  localparam int DAC_W   = 8;

  typedef struct packed {
    logic [CHAN_W-1:0] r;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] b;
  } pixel_t;

endpackage

// File: rtl/vga_scanout_if.sv
// Bundle between the scanout engine (master) and its pixel source / VGA DAC side (slave).
interface vga_scanout_if;
  import vga_timing_pkg::*;

  logic [COLOR_W-1:0]  pixel_color;
  logic [DRAW_X_W-1:0] draw_x;
  logic [DRAW_Y_W-1:0] draw_y;
  logic                draw_valid;
  logic                frame_start;
  logic [DAC_W-1:0]    VGA_R;
  logic [DAC_W-1:0]    VGA_G;
  logic [DAC_W-1:0]    VGA_B;
  logic                VGA_HS;
  logic                VGA_VS;
  logic                VGA_BLANK_N;
  logic                VGA_SYNC_N;
  logic                VGA_CLK;

  modport master (
    input  pixel_color,
    output draw_x, draw_y, draw_valid, frame_start,
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK
  );

  modport slave (
    output pixel_color,
    input  draw_x, draw_y, draw_valid, frame_start,
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK
  );

endinterface

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical scan counters advancing once per pixel enable, plus region decode.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pixEn,
  output logic [CNT_W-1:0] o_hCount,
  output logic [CNT_W-1:0] o_vCount,
  output logic             o_drawValid,
  output logic             o_hSyncActive,
  output logic             o_vSyncActive,
  output logic             o_frameStart
);

  localparam logic [CNT_W-1:0] H_VIS_END   = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG  = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_VIS_END   = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG  = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  logic [CNT_W-1:0] r_hCount;
  logic [CNT_W-1:0] r_vCount;
  logic             w_hWrap;

  assign w_hWrap = (r_hCount == H_LAST);

  // The vertical counter only moves on the pixel that closes a line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hCount <= '0;
      r_vCount <= '0;
    end else if (i_pixEn) begin
      if (w_hWrap) begin
        r_hCount <= '0;
        r_vCount <= (r_vCount == V_LAST) ? '0 : r_vCount + 1'b1;
      end else begin
        r_hCount <= r_hCount + 1'b1;
      end
    end
  end

  assign o_hCount      = r_hCount;
  assign o_vCount      = r_vCount;
  assign o_drawValid   = (r_hCount < H_VIS_END) && (r_vCount < V_VIS_END);
  assign o_hSyncActive = (r_hCount >= H_SYNC_BEG) && (r_hCount < H_SYNC_END);
  assign o_vSyncActive = (r_vCount >= V_SYNC_BEG) && (r_vCount < V_SYNC_END);
  assign o_frameStart  = i_pixEn && (r_hCount == '0) && (r_vCount == '0);

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: half-rate pixel clock, scan position to the pixel source, registered RGB/sync outputs.
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  vga_scanout_if.master vga
);

  // Replicate the 3-bit code across the byte so full scale maps to 8'hFF.
  function automatic logic [DAC_W-1:0] expandChannel(input logic [CHAN_W-1:0] c);
    return {c, c, c[2:1]};
  endfunction

  logic             r_phase;
  logic             w_pixEn;
  logic [CNT_W-1:0] w_hCount;
  logic [CNT_W-1:0] w_vCount;
  logic             w_drawValid;
  logic             w_hSyncActive;
  logic             w_vSyncActive;
  logic             w_frameStart;
  pixel_t           w_pixel;

  logic [DAC_W-1:0] r_red;
  logic [DAC_W-1:0] r_green;
  logic [DAC_W-1:0] r_blue;
  logic             r_hsN;
  logic             r_vsN;
  logic             r_blankN;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_phase <= 1'b0;
    else       r_phase <= ~r_phase;
  end

  assign w_pixEn = r_phase;
  assign w_pixel = vga.pixel_color;

  vga_sync_counter #(
    .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_syncCounter (
    .clk           (CLOCK_50),
    .rst           (reset),
    .i_pixEn       (w_pixEn),
    .o_hCount      (w_hCount),
    .o_vCount      (w_vCount),
    .o_drawValid   (w_drawValid),
    .o_hSyncActive (w_hSyncActive),
    .o_vSyncActive (w_vSyncActive),
    .o_frameStart  (w_frameStart)
  );

  // One pixel period of lag: the source sees draw_x/draw_y, the DAC sees the previous pixel.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_hsN    <= 1'b1;
      r_vsN    <= 1'b1;
      r_blankN <= 1'b0;
    end else if (w_pixEn) begin
      r_red    <= w_drawValid ? expandChannel(w_pixel.r) : '0;
      r_green  <= w_drawValid ? expandChannel(w_pixel.g) : '0;
      r_blue   <= w_drawValid ? expandChannel(w_pixel.b) : '0;
      r_hsN    <= ~w_hSyncActive;
      r_vsN    <= ~w_vSyncActive;
      r_blankN <= w_drawValid;
    end
  end

  assign vga.draw_x      = w_drawValid ? DRAW_X_W'(w_hCount) : '0;
  assign vga.draw_y      = w_drawValid ? DRAW_Y_W'(w_vCount) : '0;
  assign vga.draw_valid  = w_drawValid;
  assign vga.frame_start = w_frameStart;
  assign vga.VGA_R       = r_red;
  assign vga.VGA_G       = r_green;
  assign vga.VGA_B       = r_blue;
  assign vga.VGA_HS      = r_hsN;
  assign vga.VGA_VS      = r_vsN;
  assign vga.VGA_BLANK_N = r_blankN;
  assign vga.VGA_SYNC_N  = 1'b1;
  assign vga.VGA_CLK     = r_phase;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: a default-timing scanout for line-level checks, a shrunken one for frame-level checks.
module tb_vga_scanout;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  int   checkCount = 0;
  int   errorCount = 0;

  // Shrunken timing: 15 pixels/line (8 visible, sync at 10..12), 10 lines (6 visible, sync on 7..8).
  vga_scanout_if vgaFull();
  vga_scanout_if vgaSmall();

  vga_scanout dutFull (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .vga      (vgaFull)
  );

  vga_scanout #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dutSmall (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .vga      (vgaSmall)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_full_hs"},    vgaFull.VGA_HS, 1);
    checkOutput({tag, "_full_vs"},    vgaFull.VGA_VS, 1);
    checkOutput({tag, "_full_blank"}, vgaFull.VGA_BLANK_N, 0);
    checkOutput({tag, "_full_rgb"},   {vgaFull.VGA_R, vgaFull.VGA_G, vgaFull.VGA_B}, 0);
    checkOutput({tag, "_full_fs"},    vgaFull.frame_start, 0);
    checkOutput({tag, "_full_clk"},   vgaFull.VGA_CLK, 0);
    checkOutput({tag, "_full_x"},     vgaFull.draw_x, 0);
    checkOutput({tag, "_small_hs"},   vgaSmall.VGA_HS, 1);
    checkOutput({tag, "_small_vs"},   vgaSmall.VGA_VS, 1);
    checkOutput({tag, "_small_blank"}, vgaSmall.VGA_BLANK_N, 0);
    checkOutput({tag, "_small_rgb"},  {vgaSmall.VGA_R, vgaSmall.VGA_G, vgaSmall.VGA_B}, 0);
    checkOutput({tag, "_small_fs"},   vgaSmall.frame_start, 0);
  endtask

  // Odd k precedes a pixel-enable edge; even k precedes a non-sampling edge and gets junk.
  task automatic applyStimulus(input int k);
    if (k % 2 == 0)  vgaSmall.pixel_color = 9'h1FF;
    else if (k == 127) vgaSmall.pixel_color = 9'b001_110_000;
    else             vgaSmall.pixel_color = 9'h000;
  endtask

  int fullFsCount  = 0;
  int smallFsCount = 0;
  int fullHsLow    = 0;
  int fullHsFirst  = 0;
  int smallHsLow   = 0;
  int smallHsFirst = 0;
  int smallVsLow   = 0;
  int smallVsFirst = 0;
  int smallRgbNz   = 0;

  initial begin
    vgaFull.pixel_color  = 9'h1FF;
    vgaSmall.pixel_color = 9'h000;
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkResetState("rst_init");
    checkOutput("sync_n_full", vgaFull.VGA_SYNC_N, 1);
    checkOutput("sync_n_small", vgaSmall.VGA_SYNC_N, 1);

    @(negedge CLOCK_50);
    reset = 1'b0;
    applyStimulus(0);
    #1;
    checkOutput("fs_before_edge1", vgaFull.frame_start, 0);

    // k counts rising edges since release; sampling happens 1 time unit after each.
    for (int k = 1; k <= 3250; k++) begin
      @(posedge CLOCK_50);
      #1;
      fullFsCount  += int'(vgaFull.frame_start);
      smallFsCount += int'(vgaSmall.frame_start);
      if (!vgaFull.VGA_HS && k <= 3200) fullHsLow++;
      if (!vgaFull.VGA_HS && fullHsFirst == 0) fullHsFirst = k;
      if (!vgaSmall.VGA_HS && smallHsFirst == 0) smallHsFirst = k;
      if (!vgaSmall.VGA_VS && smallVsFirst == 0) smallVsFirst = k;
      if (k <= 300) begin
        if (!vgaSmall.VGA_HS) smallHsLow++;
        if (!vgaSmall.VGA_VS) smallVsLow++;
        if ({vgaSmall.VGA_R, vgaSmall.VGA_G, vgaSmall.VGA_B} != 24'h0) smallRgbNz++;
      end
      case (k)
        1: begin
          checkOutput("fs_full_k1", vgaFull.frame_start, 1);
          checkOutput("fs_small_k1", vgaSmall.frame_start, 1);
          checkOutput("x_full_k1", vgaFull.draw_x, 0);
          checkOutput("clk_full_k1", vgaFull.VGA_CLK, 1);
        end
        2: begin
          checkOutput("fs_full_k2", vgaFull.frame_start, 0);
          checkOutput("clk_full_k2", vgaFull.VGA_CLK, 0);
          checkOutput("x_full_k2", vgaFull.draw_x, 1);
        end
        15: begin
          checkOutput("valid_small_h7", vgaSmall.draw_valid, 1);
          checkOutput("x_small_h7", vgaSmall.draw_x, 7);
        end
        16: begin
          checkOutput("valid_small_h8", vgaSmall.draw_valid, 0);
          checkOutput("x_small_h8", vgaSmall.draw_x, 0);
        end
        17: checkOutput("blank_small_k17", vgaSmall.VGA_BLANK_N, 1);
        18: checkOutput("blank_small_k18", vgaSmall.VGA_BLANK_N, 0);
        126: begin
          checkOutput("x_small_k126", vgaSmall.draw_x, 3);
          checkOutput("y_small_k126", vgaSmall.draw_y, 4);
        end
        128, 129: begin
          checkOutput("r_small_dot", vgaSmall.VGA_R, 8'h24);
          checkOutput("g_small_dot", vgaSmall.VGA_G, 8'hDB);
          checkOutput("b_small_dot", vgaSmall.VGA_B, 8'h00);
        end
        130: checkOutput("rgb_small_after_dot", {vgaSmall.VGA_R, vgaSmall.VGA_G, vgaSmall.VGA_B}, 0);
        150: begin
          checkOutput("valid_small_v5", vgaSmall.draw_valid, 1);
          checkOutput("y_small_v5", vgaSmall.draw_y, 5);
        end
        180: begin
          checkOutput("valid_small_v6", vgaSmall.draw_valid, 0);
          checkOutput("y_small_v6", vgaSmall.draw_y, 0);
        end
        300: checkOutput("fs_small_k300", vgaSmall.frame_start, 0);
        301: checkOutput("fs_small_k301", vgaSmall.frame_start, 1);
        1279: begin
          checkOutput("x_full_639", vgaFull.draw_x, 639);
          checkOutput("valid_full_639", vgaFull.draw_valid, 1);
        end
        1280: begin
          checkOutput("valid_full_640", vgaFull.draw_valid, 0);
          checkOutput("x_full_640", vgaFull.draw_x, 0);
          checkOutput("y_full_640", vgaFull.draw_y, 0);
        end
        1281: begin
          checkOutput("blank_full_k1281", vgaFull.VGA_BLANK_N, 1);
          checkOutput("r_full_k1281", vgaFull.VGA_R, 8'hFF);
          checkOutput("b_full_k1281", vgaFull.VGA_B, 8'hFF);
        end
        1282: begin
          checkOutput("blank_full_k1282", vgaFull.VGA_BLANK_N, 0);
          checkOutput("rgb_full_k1282", {vgaFull.VGA_R, vgaFull.VGA_G, vgaFull.VGA_B}, 0);
        end
        1600: begin
          checkOutput("y_full_line1", vgaFull.draw_y, 1);
          checkOutput("x_full_line1", vgaFull.draw_x, 0);
          checkOutput("valid_full_line1", vgaFull.draw_valid, 1);
        end
        default: ;
      endcase
      applyStimulus(k);
    end

    checkOutput("full_hs_first", fullHsFirst, 1314);
    checkOutput("full_hs_low_2lines", fullHsLow, 384);
    checkOutput("full_fs_count", fullFsCount, 1);
    checkOutput("small_hs_first", smallHsFirst, 22);
    checkOutput("small_hs_low_frame", smallHsLow, 60);
    checkOutput("small_vs_first", smallVsFirst, 212);
    checkOutput("small_vs_low_frame", smallVsLow, 60);
    checkOutput("small_rgb_nonzero", smallRgbNz, 2);
    checkOutput("small_fs_count", smallFsCount, 11);

    // Mid-frame reset: small is inside vertical sync, full is drawing line 2.
    @(posedge CLOCK_50);
    #1;
    checkOutput("pre_rst_small_vs", vgaSmall.VGA_VS, 0);
    checkOutput("pre_rst_full_blank", vgaFull.VGA_BLANK_N, 1);
    checkOutput("pre_rst_full_clk", vgaFull.VGA_CLK, 1);
    #2;
    reset = 1'b1;
    #1;
    checkResetState("rst_async");
    repeat (5) @(posedge CLOCK_50);
    #1;
    checkResetState("rst_hold");

    @(negedge CLOCK_50);
    reset = 1'b0;
    vgaSmall.pixel_color = 9'h000;
    @(posedge CLOCK_50);
    #1;
    checkOutput("rel_fs_full_1", vgaFull.frame_start, 1);
    checkOutput("rel_fs_small_1", vgaSmall.frame_start, 1);
    @(posedge CLOCK_50);
    #1;
    checkOutput("rel_fs_full_2", vgaFull.frame_start, 0);
    checkOutput("rel_fs_small_2", vgaSmall.frame_start, 0);
    checkOutput("rel_x_full_2", vgaFull.draw_x, 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
